fl: RTL and testbench

- Free list for the R10K-style rename stage. It is the supply end of the physical-register tags that the map table consumes as fl_pr0/fl_pr1 at dispatch.
- It is also the return end for the Told tags the ROB frees at retirement.
- It is a 2-wide-in / 2-wide-out circular FIFO of 7-bit physical register tags, with a head pointer, a tail pointer and an occupancy counter.

---
 rtl/fl_pkg.sv | 17 +
 rtl/fl.sv | 69 ++++++
 tb/tb_fl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/fl_pkg.sv
// Rename-stage shared sizes: tag widths, register counts and the 2-wide count field.
package fl_pkg;

  localparam int PR_TAG_WIDTH = 7;
  localparam int AR_TAG_WIDTH = 5;
  localparam int AR_NUM       = 32;
  localparam int PR_NUM       = 96;
  localparam int FL_DEPTH     = PR_NUM - AR_NUM;
  localparam int FL_PTR_WIDTH = $clog2(FL_DEPTH);
  localparam int FL_CNT_WIDTH = $clog2(FL_DEPTH + 1);
  localparam int WAY_NUM_WIDTH = 2;

  typedef logic [PR_TAG_WIDTH-1:0]  pr_tag_t;
  typedef logic [AR_TAG_WIDTH-1:0]  ar_tag_t;
  typedef logic [WAY_NUM_WIDTH-1:0] way_num_t;

endpackage

// File: rtl/fl.sv
// Free list of physical tags: 2-wide pop at head, 2-wide push of Told tags at tail.
// Pops leave fl_pr* at the consuming edge, pushes appear the cycle after; no backpressure, over/underflow set sticky fl_error.
module fl
  import fl_pkg::*;
(
  input  logic           clock,
  input  logic           reset,
  input  way_num_t       rob_dispatch_num,
  input  way_num_t       rob_retire_num,
  input  pr_tag_t        rob_retire_told0,
  input  pr_tag_t        rob_retire_told1,
  output pr_tag_t        fl_pr0,
  output pr_tag_t        fl_pr1,
  output way_num_t       fl_avail_num,
  output logic [FL_CNT_WIDTH-1:0] fl_count,
  output logic           fl_error
);

  pr_tag_t                   mem [FL_DEPTH];
  logic [FL_PTR_WIDTH-1:0]   head;
  logic [FL_PTR_WIDTH-1:0]   tail;
  logic [FL_PTR_WIDTH-1:0]   head_p1;
  logic [FL_PTR_WIDTH-1:0]   tail_p1;
  logic [FL_CNT_WIDTH-1:0]   count;
  logic [FL_CNT_WIDTH-1:0]   after_disp;
  logic [FL_CNT_WIDTH-1:0]   room;
  way_num_t                  disp_acc;
  way_num_t                  ret_acc;
  logic                      underflow;
  logic                      overflow;

  assign head_p1 = head + FL_PTR_WIDTH'(1);
  assign tail_p1 = tail + FL_PTR_WIDTH'(1);

  // Dispatch is resolved first so a same-cycle pop makes room for the retire push.
  always_comb begin
    underflow  = FL_CNT_WIDTH'(rob_dispatch_num) > count;
    disp_acc   = underflow ? count[WAY_NUM_WIDTH-1:0] : rob_dispatch_num;
    after_disp = count - FL_CNT_WIDTH'(disp_acc);
    room       = FL_CNT_WIDTH'(FL_DEPTH) - after_disp;
    overflow   = FL_CNT_WIDTH'(rob_retire_num) > room;
    ret_acc    = overflow ? room[WAY_NUM_WIDTH-1:0] : rob_retire_num;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FL_DEPTH; i++) begin
        mem[i] <= PR_TAG_WIDTH'(AR_NUM + i);
      end
      head     <= '0;
      tail     <= '0;
      count    <= FL_CNT_WIDTH'(FL_DEPTH);
      fl_error <= 1'b0;
    end else begin
      if (ret_acc != 2'd0) mem[tail]    <= rob_retire_told0;
      if (ret_acc == 2'd2) mem[tail_p1] <= rob_retire_told1;
      head     <= head + FL_PTR_WIDTH'(disp_acc);
      tail     <= tail + FL_PTR_WIDTH'(ret_acc);
      count    <= after_disp + FL_CNT_WIDTH'(ret_acc);
      fl_error <= fl_error | underflow | overflow;
    end
  end

  assign fl_pr0       = mem[head];
  assign fl_pr1       = mem[head_p1];
  assign fl_avail_num = (count >= FL_CNT_WIDTH'(2)) ? 2'd2 : count[WAY_NUM_WIDTH-1:0];
  assign fl_count     = count;

endmodule

// File: tb/tb_fl.sv
// Bench for the free list: directed scenarios plus random traffic against a queue model.
module tb_fl;
  import fl_pkg::*;

  logic           clock;
  logic           reset;
  way_num_t       rob_dispatch_num;
  way_num_t       rob_retire_num;
  pr_tag_t        rob_retire_told0;
  pr_tag_t        rob_retire_told1;
  pr_tag_t        fl_pr0;
  pr_tag_t        fl_pr1;
  way_num_t       fl_avail_num;
  logic [FL_CNT_WIDTH-1:0] fl_count;
  logic           fl_error;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: the list is a plain queue of tags plus a sticky error bit.
  int q[$];
  bit m_err;

  fl dut (
    .clock            (clock),
    .reset            (reset),
    .rob_dispatch_num (rob_dispatch_num),
    .rob_retire_num   (rob_retire_num),
    .rob_retire_told0 (rob_retire_told0),
    .rob_retire_told1 (rob_retire_told1),
    .fl_pr0           (fl_pr0),
    .fl_pr1           (fl_pr1),
    .fl_avail_num     (fl_avail_num),
    .fl_count         (fl_count),
    .fl_error         (fl_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    for (int i = 0; i < 64; i++) q.push_back(32 + i);
    m_err = 1'b0;
  endfunction

  function automatic void model_step(input int disp, input int rn, input int t0, input int t1);
    int d;
    int room;
    int acc;
    d = (disp > q.size()) ? q.size() : disp;
    if (disp > q.size()) m_err = 1'b1;
    for (int i = 0; i < d; i++) void'(q.pop_front());
    room = 64 - q.size();
    acc  = (rn > room) ? room : rn;
    if (rn > room) m_err = 1'b1;
    if (acc >= 1) q.push_back(t0);
    if (acc >= 2) q.push_back(t1);
  endfunction

  task automatic check_outputs(input string tag);
    int sz;
    sz = q.size();
    check({tag, ".count"}, 32'(fl_count), 32'(sz));
    check({tag, ".avail"}, 32'(fl_avail_num), 32'((sz >= 2) ? 2 : sz));
    check({tag, ".error"}, 32'(fl_error), 32'(m_err));
    if (sz >= 1) check({tag, ".pr0"}, 32'(fl_pr0), 32'(q[0]));
    if (sz >= 2) check({tag, ".pr1"}, 32'(fl_pr1), 32'(q[1]));
  endtask

  task automatic step(input string tag, input int disp, input int rn, input int t0, input int t1);
    rob_dispatch_num = way_num_t'(disp);
    rob_retire_num   = way_num_t'(rn);
    rob_retire_told0 = pr_tag_t'(t0);
    rob_retire_told1 = pr_tag_t'(t1);
    @(posedge clock);
    model_step(disp, rn, t0, t1);
    #1;
    check_outputs(tag);
  endtask

  task automatic async_reset(input string tag);
    @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    check_outputs(tag);
    #2;
    reset = 1'b1;
  endtask

  initial begin
    reset            = 1'b0;
    rob_dispatch_num = '0;
    rob_retire_num   = '0;
    rob_retire_told0 = '0;
    rob_retire_told1 = '0;
    model_reset();
    #12;
    check("rst.pr0",   32'(fl_pr0), 32);
    check("rst.pr1",   32'(fl_pr1), 33);
    check("rst.avail", 32'(fl_avail_num), 2);
    check("rst.count", 32'(fl_count), 64);
    check("rst.error", 32'(fl_error), 0);
    reset = 1'b1;

    for (int i = 0; i < 3; i++) step("idle", 0, 0, 0, 0);

    for (int i = 0; i < 32; i++) begin
      check("drain.pr0", 32'(fl_pr0), 32'(32 + 2 * i));
      check("drain.pr1", 32'(fl_pr1), 32'(33 + 2 * i));
      step("drain", 2, 0, 0, 0);
    end

    step("ret2", 0, 2, 5, 9);
    check("ret2.pr0", 32'(fl_pr0), 5);
    check("ret2.pr1", 32'(fl_pr1), 9);
    step("disp1", 1, 0, 0, 0);
    check("disp1.pr0", 32'(fl_pr0), 9);

    async_reset("wrap.rst");
    for (int i = 0; i < 31; i++) step("wrap.drain", 2, 0, 0, 0);
    step("wrap.ret1", 0, 1, 77, 0);
    step("wrap.disp1", 1, 0, 0, 0);
    check("wrap.pr0", 32'(fl_pr0), 95);
    check("wrap.pr1", 32'(fl_pr1), 77);
    step("wrap.disp2", 2, 0, 0, 0);

    async_reset("full.rst");
    step("full.swap", 1, 1, 7, 0);
    step("full.over", 0, 1, 11, 0);
    for (int i = 0; i < 31; i++) step("full.drain", 2, 0, 0, 0);
    step("full.tail", 1, 0, 0, 0);
    check("full.tag7", 32'(fl_pr0), 7);

    async_reset("under.rst");
    for (int i = 0; i < 31; i++) step("under.drain", 2, 0, 0, 0);
    step("under.one", 1, 0, 0, 0);
    step("under.two", 2, 0, 0, 0);
    check("under.error", 32'(fl_error), 1);
    async_reset("under.async");

    for (int i = 0; i < 3000; i++) begin
      int disp;
      int rn;
      if ($urandom_range(0, 399) == 0) begin
        async_reset("rand.rst");
      end
      disp = $urandom_range(0, 2);
      rn   = $urandom_range(0, 2);
      if (q.size() > 48 && $urandom_range(0, 1) == 1) rn = 0;
      if (q.size() < 16 && $urandom_range(0, 1) == 1) disp = 0;
      step("rand", disp, rn, int'($urandom_range(0, 127)), int'($urandom_range(0, 127)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
